// File: rtl/collision_ctrl_if.sv
// Bundles the game-control inputs (frame strobe, start button, two bounding boxes) and status outputs.
// Latency: none, pure wiring between the controller and its environment.
// Backpressure: none; the strobe is a one-cycle event and every output is a level.
interface collision_ctrl_if #(
   parameter int SCORE_W = 16
);
   logic               i_ani_stb;
   logic               i_start;
   logic [11:0]        i_dino_x1;
   logic [11:0]        i_dino_x2;
   logic [11:0]        i_dino_y1;
   logic [11:0]        i_dino_y2;
   logic [11:0]        i_obs_x1;
   logic [11:0]        i_obs_x2;
   logic [11:0]        i_obs_y1;
   logic [11:0]        i_obs_y2;
   logic               i_obs_valid;
   logic               o_animate;
   logic               o_game_over;
   logic               o_hit_pulse;
   logic [SCORE_W-1:0] o_score;
   logic [1:0]         o_state;

   // Environment side: drives the inputs and observes the status.
   modport master (
      output i_ani_stb, i_start,
      output i_dino_x1, i_dino_x2, i_dino_y1, i_dino_y2,
      output i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2, i_obs_valid,
      input  o_animate, o_game_over, o_hit_pulse, o_score, o_state
   );

   // Controller side.
   modport slave (
      input  i_ani_stb, i_start,
      input  i_dino_x1, i_dino_x2, i_dino_y1, i_dino_y2,
      input  i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2, i_obs_valid,
      output o_animate, o_game_over, o_hit_pulse, o_score, o_state
   );
endinterface

// File: rtl/collision_ctrl.sv
// Game controller: IDLE/RUN/OVER FSM with box collision detection, scoring and restart lockout.
// Latency: every output is registered and reflects the inputs sampled one clock earlier.
// Backpressure: none; it acts on the frame strobe whenever that strobe is high.
module collision_ctrl #(
   parameter int SCORE_W        = 16,
   parameter int SCORE_DIV      = 6,
   parameter int HIT_FRAMES     = 2,
   parameter int LOCKOUT_FRAMES = 30
) (
   input  logic               i_clk,
   input  logic               i_rst,
   collision_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [7:0]         DIV_LAST  = 8'(SCORE_DIV - 1);
   localparam logic [3:0]         HIT_N     = 4'(HIT_FRAMES);
   localparam logic [7:0]         LOCK_INIT = 8'(LOCKOUT_FRAMES);

   state_e             state_q, state_d;
   logic               start_prev_q, start_prev_d;
   logic               rst_hold_q, rst_hold_d;
   logic [3:0]         hit_q, hit_d;
   logic [7:0]         div_q, div_d;
   logic [7:0]         lock_q, lock_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               hit_pulse_q, hit_pulse_d;
   logic               animate_q, animate_d;
   logic               game_over_q, game_over_d;

   logic               start_edge;
   logic               overlap;
   logic [3:0]         hit_next;

   // Rising edge of the start button; rst_hold_q masks the first cycle after reset so a
   // button already held during reset does not count as a press.
   assign start_edge = bus.i_start & ~start_prev_q & ~rst_hold_q;

   // Strict unsigned overlap: boxes that only share an edge do not collide.
   assign overlap = bus.i_obs_valid &
                    (bus.i_dino_x1 < bus.i_obs_x2) & (bus.i_obs_x1 < bus.i_dino_x2) &
                    (bus.i_dino_y1 < bus.i_obs_y2) & (bus.i_obs_y1 < bus.i_dino_y2);

   assign hit_next = hit_q + 4'd1;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d      = state_q;
      hit_d        = hit_q;
      div_d        = div_q;
      lock_d       = lock_q;
      score_d      = score_q;
      hit_pulse_d  = 1'b0;
      start_prev_d = bus.i_start;
      rst_hold_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_RUN;
               hit_d   = 4'd0;
               div_d   = 8'd0;
               score_d = '0;
            end
         end
         ST_RUN: begin
            if (bus.i_ani_stb) begin
               if (overlap && (hit_next == HIT_N)) begin
                  // The ending hit wins over a score point due on the same strobe.
                  state_d     = ST_OVER;
                  hit_d       = hit_next;
                  hit_pulse_d = 1'b1;
                  lock_d      = LOCK_INIT;
               end else begin
                  hit_d = overlap ? hit_next : 4'd0;
                  if (div_q == DIV_LAST) begin
                     div_d = 8'd0;
                     if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_W'(1);
                     end
                  end else begin
                     div_d = div_q + 8'd1;
                  end
               end
            end
         end
         ST_OVER: begin
            // Presses during lockout are simply dropped; only a fresh press after it counts.
            if (start_edge && (lock_q == 8'd0)) begin
               state_d = ST_RUN;
               hit_d   = 4'd0;
               div_d   = 8'd0;
               score_d = '0;
            end else if (bus.i_ani_stb && (lock_q != 8'd0)) begin
               lock_d = lock_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      animate_d   = (state_d == ST_RUN);
      game_over_d = (state_d == ST_OVER);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         rst_hold_q   <= 1'b1;
         hit_q        <= 4'd0;
         div_q        <= 8'd0;
         lock_q       <= 8'd0;
         score_q      <= '0;
         hit_pulse_q  <= 1'b0;
         animate_q    <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         rst_hold_q   <= rst_hold_d;
         hit_q        <= hit_d;
         div_q        <= div_d;
         lock_q       <= lock_d;
         score_q      <= score_d;
         hit_pulse_q  <= hit_pulse_d;
         animate_q    <= animate_d;
         game_over_q  <= game_over_d;
      end
   end

   assign bus.o_state     = state_q;
   assign bus.o_animate   = animate_q;
   assign bus.o_game_over = game_over_q;
   assign bus.o_hit_pulse = hit_pulse_q;
   assign bus.o_score     = score_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Bench for collision_ctrl: scripted game scenarios on a default instance and a 4-bit-score instance.
// Latency: expectations are queued with each stimulus step and compared one clock later.
// Backpressure: none; strobes are issued every other cycle.
module tb_collision_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1;
   logic rst2;

   collision_ctrl_if #(.SCORE_W(16)) b1 ();
   collision_ctrl_if #(.SCORE_W(4))  b2 ();

   collision_ctrl #(
      .SCORE_W(16), .SCORE_DIV(6), .HIT_FRAMES(2), .LOCKOUT_FRAMES(30)
   ) u_dut (
      .i_clk (clk),
      .i_rst (rst1),
      .bus   (b1.slave)
   );

   collision_ctrl #(
      .SCORE_W(4), .SCORE_DIV(6), .HIT_FRAMES(2), .LOCKOUT_FRAMES(30)
   ) u_dut_w4 (
      .i_clk (clk),
      .i_rst (rst2),
      .bus   (b2.slave)
   );

   localparam int K_STATE = 0;
   localparam int K_ANIM  = 1;
   localparam int K_GO    = 2;
   localparam int K_PULSE = 3;
   localparam int K_SCORE = 4;

   typedef struct {
      string tag;
      int    dut;
      int    kind;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int dut, input int kind);
      logic [31:0] v;
      v = '0;
      if (dut == 1) begin
         case (kind)
            K_STATE: v = 32'(b1.o_state);
            K_ANIM:  v = 32'(b1.o_animate);
            K_GO:    v = 32'(b1.o_game_over);
            K_PULSE: v = 32'(b1.o_hit_pulse);
            default: v = 32'(b1.o_score);
         endcase
      end else begin
         case (kind)
            K_STATE: v = 32'(b2.o_state);
            K_ANIM:  v = 32'(b2.o_animate);
            K_GO:    v = 32'(b2.o_game_over);
            K_PULSE: v = 32'(b2.o_hit_pulse);
            default: v = 32'(b2.o_score);
         endcase
      end
      return v;
   endfunction

   task automatic push(input string tag, input int dut, input int kind, input int val);
      exp_t e;
      e.tag = tag; e.dut = dut; e.kind = kind; e.val = val;
      sb.push_back(e);
   endtask

   // Queue a full expected status (state, animate, game_over, hit_pulse, score).
   task automatic push_all(input string tag, input int dut, input int st, input int an,
                           input int go, input int pl, input int sc);
      push({tag, ".state"}, dut, K_STATE, st);
      push({tag, ".anim"},  dut, K_ANIM,  an);
      push({tag, ".go"},    dut, K_GO,    go);
      push({tag, ".pulse"}, dut, K_PULSE, pl);
      push({tag, ".score"}, dut, K_SCORE, sc);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, observe(e.dut, e.kind), 32'(e.val));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame strobe followed by an idle cycle, on both instances.
   task automatic strobe(input int n);
      for (int i = 0; i < n; i++) begin
         b1.i_ani_stb = 1'b1; b2.i_ani_stb = 1'b1;
         tick();
         b1.i_ani_stb = 1'b0; b2.i_ani_stb = 1'b0;
         tick();
      end
   endtask

   task automatic set_obs(input int x1, input int x2, input logic vld);
      b1.i_obs_x1 = 12'(x1); b1.i_obs_x2 = 12'(x2);
      b1.i_obs_y1 = 12'd100; b1.i_obs_y2 = 12'd140;
      b1.i_obs_valid = vld;
   endtask

   task automatic press1();
      b1.i_start = 1'b1; tick();
      b1.i_start = 1'b0; tick();
   endtask

   initial begin
      rst1 = 1'b1; rst2 = 1'b1;
      b1.i_ani_stb = 1'b0; b1.i_start = 1'b0;
      b1.i_dino_x1 = 12'd10;  b1.i_dino_x2 = 12'd30;
      b1.i_dino_y1 = 12'd100; b1.i_dino_y2 = 12'd140;
      set_obs(0, 0, 1'b0);
      b2.i_ani_stb = 1'b0; b2.i_start = 1'b0;
      b2.i_dino_x1 = 12'd0; b2.i_dino_x2 = 12'd0; b2.i_dino_y1 = 12'd0; b2.i_dino_y2 = 12'd0;
      b2.i_obs_x1  = 12'd0; b2.i_obs_x2  = 12'd0; b2.i_obs_y1  = 12'd0; b2.i_obs_y2  = 12'd0;
      b2.i_obs_valid = 1'b0;

      // Reset state.
      tick(); tick();
      push_all("reset", 1, 0, 0, 0, 0, 0);
      drain();
      rst1 = 1'b0;
      tick();

      // Start press enters RUN on the next cycle.
      b1.i_start = 1'b1; tick();
      push_all("start", 1, 1, 1, 0, 0, 0);
      drain();
      b1.i_start = 1'b0; tick();

      // Scoring: 60 strobes give 10 points, then the divider restarts from 0.
      strobe(60);
      push("score60", 1, K_SCORE, 10);
      drain();
      strobe(5);
      push("score65", 1, K_SCORE, 10);
      drain();
      strobe(1);
      push("score66", 1, K_SCORE, 11);
      drain();

      // Touching boxes never collide.
      set_obs(30, 40, 1'b1);
      strobe(5);
      push("touch.state", 1, K_STATE, 1);
      push("touch.pulse", 1, K_PULSE, 0);
      push("touch.score", 1, K_SCORE, 11);
      drain();

      // Real overlap: first strobe counts (and scores, divider at 5), second ends the game.
      set_obs(25, 40, 1'b1);
      strobe(1);
      push("hit1.state", 1, K_STATE, 1);
      push("hit1.score", 1, K_SCORE, 12);
      drain();
      b1.i_ani_stb = 1'b1; tick();
      push_all("hit2", 1, 2, 0, 1, 1, 12);
      drain();
      b1.i_ani_stb = 1'b0; tick();
      push_all("hit2.after", 1, 2, 0, 1, 0, 12);
      drain();

      // Lockout: presses at strobe 10 and 29 are discarded, a press after 30 restarts.
      strobe(10);
      press1();
      push("lock10", 1, K_STATE, 2);
      drain();
      strobe(19);
      press1();
      push("lock29", 1, K_STATE, 2);
      drain();
      strobe(1);
      push("lock30.noqueue", 1, K_STATE, 2);
      push("lock30.score", 1, K_SCORE, 12);
      drain();
      b1.i_start = 1'b1; tick();
      push_all("restart", 1, 1, 1, 0, 0, 0);
      drain();
      b1.i_start = 1'b0; tick();

      // Alternating overlap keeps RUN; two in a row on the 6th strobe ends it without scoring.
      for (int i = 0; i < 5; i++) begin
         set_obs(25, 40, (i % 2) == 0);
         strobe(1);
      end
      push("alt.state", 1, K_STATE, 1);
      push("alt.score", 1, K_SCORE, 0);
      drain();
      set_obs(25, 40, 1'b1);
      strobe(1);
      push("prio.state", 1, K_STATE, 2);
      push("prio.score", 1, K_SCORE, 0);
      drain();

      // Reset during lockout with start held high: IDLE, and the held button is not a press.
      b1.i_start = 1'b1; rst1 = 1'b1; tick();
      push_all("rst.lock", 1, 0, 0, 0, 0, 0);
      drain();
      rst1 = 1'b0; tick(); tick();
      push_all("rst.held", 1, 0, 0, 0, 0, 0);
      drain();
      b1.i_start = 1'b0; tick();
      b1.i_start = 1'b1; tick();
      push("repress.state", 1, K_STATE, 1);
      drain();
      b1.i_start = 1'b0;

      // 4-bit score instance: saturates at 15.
      rst2 = 1'b0; tick();
      b2.i_start = 1'b1; tick();
      push_all("w4.start", 2, 1, 1, 0, 0, 0);
      drain();
      b2.i_start = 1'b0;
      strobe(90);
      push("w4.score90", 2, K_SCORE, 15);
      drain();
      strobe(10);
      push("w4.score100", 2, K_SCORE, 15);
      push("w4.state", 2, K_STATE, 1);
      drain();

      // Reset mid-RUN clears everything on the next cycle.
      rst2 = 1'b1; tick();
      push_all("w4.rst", 2, 0, 0, 0, 0, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/collision_ctrl.md
COLLISION_CTRL -- requirements
Module: collision_ctrl

Interface
REQ-001 SHALL have parameter SCORE_W, default 16, score counter width in bits.
REQ-002 SHALL have parameter SCORE_DIV, default 6, frame strobes per score point (valid range 1..255).
REQ-003 SHALL have parameter HIT_FRAMES, default 2, consecutive overlapping frames that end the game (valid range 1..15).
REQ-004 SHALL have parameter LOCKOUT_FRAMES, default 30, frames after game over during which start is ignored (valid range 0..255).
REQ-005 SHALL have port i_clk  in  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_ani_stb  in  1  one-cycle frame strobe, same strobe as the dinosaur animation.
REQ-008 SHALL have port i_start  in  1  start/jump button level, already synchronised.
REQ-009 SHALL have ports i_dino_x1, i_dino_x2, i_dino_y1, i_dino_y2  in  12 each  dinosaur box edges.
REQ-010 SHALL have ports i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2  in  12 each  obstacle box edges.
REQ-011 SHALL have port i_obs_valid  in  1  obstacle box present on screen.
REQ-012 SHALL have port o_animate  out  1  animation enable to the dinosaur and obstacle blocks.
REQ-013 SHALL have port o_game_over  out  1  high while in OVER.
REQ-014 SHALL have port o_hit_pulse  out  1  single-cycle pulse on the RUN->OVER transition.
REQ-015 SHALL have port o_score  out  SCORE_W  current score.
REQ-016 SHALL have port o_state  out  2  state code: IDLE=0, RUN=1, OVER=2.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, OVER; code 3 unreachable, recovers to IDLE on the next cycle.
REQ-018 SHALL detect a start edge as i_start high while the registered previous i_start is low, evaluated every clock.
REQ-019 SHALL treat boxes as overlapping iff i_obs_valid and dx1<ox2 and ox1<dx2 and dy1<oy2 and oy1<dy2 (unsigned, strict; shared edges do not collide).
REQ-020 SHALL evaluate overlap only on cycles where i_ani_stb=1 and state=RUN, using the inputs on that cycle.
REQ-021 IDLE: o_animate=0, o_game_over=0; start edge -> RUN next cycle, score, hit counter and frame divider cleared.
REQ-022 RUN: o_animate=1; start edges ignored.
REQ-023 RUN: 4-bit hit counter increments on each overlapping strobe and clears on each non-overlapping strobe; unchanged on non-strobe cycles.
REQ-024 RUN: when an overlapping strobe brings the hit counter to HIT_FRAMES -> OVER next cycle, with o_hit_pulse=1 for exactly that one cycle.
REQ-025 RUN: 8-bit frame divider counts strobes; on the strobe where it reaches SCORE_DIV-1 it wraps to 0 and the score increments.
REQ-026 SHALL saturate the score at 2^SCORE_W-1 (no wrap).
REQ-027 SHALL give the hit priority over scoring when both fall on the same strobe: transition to OVER, score not incremented.
REQ-028 OVER: o_animate=0, o_game_over=1, score frozen; lockout counter loaded with LOCKOUT_FRAMES on entry and decremented per strobe to 0.
REQ-029 OVER: start edge while the lockout counter is 0 -> RUN next cycle with score, hit counter and divider cleared; start edges during lockout are discarded, not queued.
REQ-030 SHALL register all outputs; state-dependent outputs follow the state register with no combinational path from inputs.

Reset
REQ-031 On i_rst=1: state=IDLE, o_animate=0, o_game_over=0, o_hit_pulse=0, o_score=0, hit counter, divider and lockout=0, previous-start register=0.
REQ-032 SHALL let i_rst override all other activity on the same cycle, including mid-RUN and mid-lockout; a start held high across reset release is not an edge.

Verification
REQ-033 Reset, then i_start 0->1 -> o_state=1 and o_animate=1 on the next cycle, o_score=0.
REQ-034 RUN, no obstacle, 60 strobes (SCORE_DIV=6) -> o_score=10; divider=0.
REQ-035 RUN, dino x 10..30 y 100..140, obstacle x 30..40 y 100..140 (touching) for 5 strobes -> no hit; obstacle x 25..40 for 2 strobes -> OVER, single o_hit_pulse, o_animate=0.
REQ-036 RUN, overlap/no-overlap alternating on strobes with HIT_FRAMES=2 -> stays RUN; overlap on the 6th strobe of a score period -> OVER, score unchanged.
REQ-037 OVER, start edge at strobe 10 (LOCKOUT_FRAMES=30) -> remains OVER; start edge after 30 strobes -> RUN with o_score=0.
REQ-038 SCORE_W=4, 96+ strobes in RUN -> o_score holds at 15; i_rst mid-RUN -> IDLE, all outputs zero next cycle.
